// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared types and defaults for the row-shift stages
package crypto_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ROWS   = 4;

endpackage

// File: rtl/inv_shift_rows_seq_row_rotr_step.sv
// rtl/inv_shift_rows_seq_row_rotr_step.sv - one inverse-shift step: rotate rows r>step right by one bit
module row_rotr_step #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int STEP_W = $clog2(ROWS)
) (
    input  logic [DATA_W-1:0] work,
    input  logic [STEP_W-1:0] step,
    output logic [DATA_W-1:0] work_next
);

    localparam int COLS = DATA_W / ROWS;

    always_comb begin
        work_next = work;
        // Row 0 is never touched; row r keeps rotating until step reaches r.
        for (int r = 1; r < ROWS; r++) begin
            if (r > int'(step)) begin
                work_next[r*COLS +: COLS] = {work[r*COLS], work[r*COLS+1 +: COLS-1]};
            end
        end
    end

endmodule

// File: rtl/inv_shift_rows_seq.sv
// rtl/inv_shift_rows_seq.sv - sequential inverse ShiftRows with valid/ready on both sides
module inv_shift_rows_seq
    import crypto_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ROWS   = DEFAULT_ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam int STEP_W = $clog2(ROWS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ROWS - 2);

    generate
        if (ROWS < 2 || (DATA_W % ROWS) != 0 || (DATA_W / ROWS) < ROWS) begin : g_bad_param
            $error("inv_shift_rows_seq: illegal DATA_W/ROWS combination");
        end
    endgenerate

    fsm_t              state_q;
    fsm_t              state_d;
    logic [STEP_W-1:0] step_q;
    logic [DATA_W-1:0] work_q;
    logic [DATA_W-1:0] work_next;
    logic              accept;
    logic              finish_shift;
    logic              release_out;

    row_rotr_step #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS),
        .STEP_W (STEP_W)
    ) u_step (
        .work      (work_q),
        .step      (step_q),
        .work_next (work_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        finish_shift = 1'b0;
        release_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (step_q == LAST_STEP) begin
                    finish_shift = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides any handshake decided above.
        if (clr) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q    <= '0;
            work_q    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            step_q    <= '0;
            work_q    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                work_q <= data_in;
                step_q <= '0;
            end else if (state_q == SHIFT) begin
                work_q <= work_next;
                step_q <= step_q + STEP_W'(1);
            end
            if (finish_shift) begin
                data_out  <= work_next;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign in_ready = rst && (state_q == IDLE);
    assign busy     = (state_q != IDLE);

endmodule
